// File: rtl/seq_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier with per-operand signedness and valid/ready handshake.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign_a,
    input  logic               sign_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] mcand, acc, acc_sum, prod_res;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic [CNT_W-1:0]   cnt;
    logic               neg, signed_mode, last_iter, accept, ovf_res;

    // Datapath works on magnitudes; MIN negates to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a    = (sign_a && a[WIDTH-1]) ? -a : a;
        mag_b    = (sign_b && b[WIDTH-1]) ? -b : b;
        acc_sum  = acc + (mplier[0] ? mcand : '0);
        prod_res = neg ? -acc_sum : acc_sum;
        if (signed_mode)
            ovf_res = prod_res[2*WIDTH-1:WIDTH] != {WIDTH{prod_res[WIDTH-1]}};
        else
            ovf_res = prod_res[2*WIDTH-1:WIDTH] != '0;
`ifdef EARLY_TERM_EN
        last_iter = (cnt == CNT_W'(1)) || ((mplier >> 1) == '0);
`else
        last_iter = (cnt == CNT_W'(1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (last_iter)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            signed_mode <= 1'b0;
            prod        <= '0;
            overflow    <= 1'b0;
        end else if (accept) begin
            mcand       <= {{WIDTH{1'b0}}, mag_a};
            mplier      <= mag_b;
            acc         <= '0;
            cnt         <= CNT_W'(WIDTH);
            neg         <= (sign_a & a[WIDTH-1]) ^ (sign_b & b[WIDTH-1]);
            signed_mode <= sign_a | sign_b;
        end else if (state == BUSY) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (last_iter) begin
                prod     <= prod_res;
                overflow <= ovf_res;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier (WIDTH=32); latency expectations follow EARLY_TERM_EN.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready;
    logic [W-1:0]   a, b;
    logic           sign_a, sign_b;
    logic           out_valid, out_ready;
    logic [2*W-1:0] prod;
    logic           overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod     (prod),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv, input logic sb);
`ifdef EARLY_TERM_EN
        logic [W-1:0] mag;
        int           l;
        mag = (sb && bv[W-1]) ? -bv : bv;
        l = 1;
        for (int k = 0; k < W; k++)
            if (mag[k]) l = k + 1;
        return l;
`else
        return W;
`endif
    endfunction

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sa, input logic sb, input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = av; b = bv; sign_a = sa; sign_b = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1; b = '1; sign_a = ~sa; sign_b = ~sb;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sa, input logic sb,
                          input logic [63:0] exp_prod, input logic exp_ovf, input string tag);
        int lat;
        start_op(av, bv, sa, sb, tag);
        wait_done(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(bv, sb)));
        check({tag, "_prod"}, prod, exp_prod);
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sign_a = 1'b0; sign_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", prod, 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        run_op(32'd7, 32'd6, 1'b0, 1'b0, 64'h2A, 1'b0, "t1");
        run_op(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0, "t2s");
        run_op(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 64'h1_FFFFFFFE, 1'b1, "t2u");
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000, 1'b1, "t3min");
        run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 1'b0, "neg3x5");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h1, 1'b0, "m1xm1");
        run_op(32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h1_00000000, 1'b1, "u2p32");
        run_op(32'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h6_FFFFFFF9, 1'b1, "mixed");
        run_op(32'd5, 32'd0, 1'b0, 1'b0, 64'h0, 1'b0, "bzero");

        // DONE must hold the result and refuse new operands while the consumer stalls.
        start_op(32'd9, 32'd9, 1'b0, 1'b0, "t4");
        wait_done("t4", lat);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            a = 32'(c); b = 32'd3;
            @(posedge clk); #1;
            check("t4_hold_prod", prod, 64'd81);
            check("t4_hold_in_ready", 64'(in_ready), 64'd0);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t4_release_in_ready", 64'(in_ready), 64'd1);
        check("t4_release_valid", 64'(out_valid), 64'd0);
        check("t4_retain_prod", prod, 64'd81);
        @(posedge clk); #1;
        check("t4_no_accept", 64'(in_ready), 64'd1);

        start_op(32'd11, 32'd13, 1'b0, 1'b0, "t5");
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_prod", prod, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 1'b0, "t5_after");

        for (int i = 1; i <= 7; i++)
            for (int j = 1; j <= 7; j++)
                run_op(32'(i), 32'(j), 1'b0, 1'b0, 64'(i * j), 1'b0, "sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
